micro_sequencer: RTL
====================

// Module: micro_sequencer
// PURPOSE
//  Fetch/decode/execute sequencer driving control_unit. Fetches 16-bit instructions
//  {opcode[7:0], op1[3:0], op2[3:0]} from instruction memory over a req/valid handshake.
//  Steps control_unit through each opcode's micro-routine: addr_ins = micro-address,
//  operand1/operand2 from the IR. Samples the routine-end and branch bits of the returned
//  control word. Owns the PC; sits between instruction memory, control_unit and the ALU flags.
// PARAMETERS
//  PC_W        8      program counter / imem address width
//  HALT_OP     8'hFF  opcode that stops the sequencer
//  MAX_UOPS    8      micro-ops per instruction before a fault is declared (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous active-high reset
//  start       in   1   one-cycle pulse, IDLE -> FETCH
//  imem_req    out  1   fetch request
//  imem_addr   out  8   fetch address (= pc)
//  imem_valid  in   1   instruction present on imem_data this cycle
//  imem_data   in   16  {opcode, op1, op2}
//  addr_ins    out  8   micro-address to control_unit
//  operand1    out  4   IR[7:4]
//  operand2    out  4   IR[3:0]
//  cu_en       out  1   control_unit enable (one issue per assertion)
//  cw_last     in   1   control word bit 39: last micro-op of routine
//  cw_branch   in   1   control word bit 38: conditional branch on zero
//  zero_flag   in   1   ALU zero flag, valid alongside control word
//  stall       in   1   datapath busy; hold issue
//  busy        out  1   state != IDLE and != HALT
//  halted      out  1   in HALT state
//  fault       out  1   sticky: MAX_UOPS exceeded
// BEHAVIOUR
//  Reset: state=IDLE; pc=0, IR=0, uaddr=0, ucnt=0.
//   All outputs 0: imem_req, cu_en, busy, halted, fault, addr_ins, operands.
//  States IDLE, FETCH, DECODE, ISSUE, EVAL, HALT. All outputs registered.
//  IDLE: start=1 -> FETCH, pc=0. Other inputs ignored.
//  FETCH: imem_req=1, imem_addr=pc, held until imem_valid.
//   On the valid cycle: IR<=imem_data, imem_req drops next cycle -> DECODE.
//   imem_valid with imem_req=0 is ignored.
//  DECODE (1 cycle): opcode==HALT_OP -> HALT.
//   Otherwise uaddr<=opcode, ucnt<=0 -> ISSUE.
//  ISSUE: stall=1 -> cu_en=0, remain in ISSUE.
//   stall=0 -> cu_en=1 for exactly one cycle with addr_ins=uaddr -> EVAL.
//  EVAL (control_unit has 1-cycle latency; sample cw_* and zero_flag here):
//   cw_last=1 & cw_branch=1 & zero_flag=1 -> pc<=IR[7:0] ({op1,op2}) -> FETCH.
//   cw_last=1, otherwise -> pc<=pc+1, 8'hFF wraps to 0 -> FETCH.
//   cw_last=0 & ucnt==MAX_UOPS-1 -> fault<=1 -> HALT.
//   cw_last=0, otherwise -> uaddr<=uaddr+1 (wraps), ucnt++ -> ISSUE.
//   cw_branch with cw_last=0: ignored.
//  HALT: halted=1, busy=0; start ignored; only rst exits.
//  Minimum instruction time, 1 micro-op with no stalls and imem_valid on the first
//   FETCH cycle: FETCH, DECODE, ISSUE, EVAL = 4 cycles.
//  rst in any state, including mid-fetch or mid-routine: next cycle is IDLE,
//   reset values restored, the pending fetch is abandoned.
//  operand1/operand2 track IR and are stable for the whole routine.
// TESTING
//  1. rst, start; imem: pc0 = 16'h0A01 (1 uop, last=1), pc1 = 16'hFF00
//     -> addr_ins=0x0A with cu_en for 1 cycle, operand1=0, operand2=1;
//        pc=1, then halted=1, fault=0.
//  2. 3-uop routine at opcode 0x20, last=1 on the 3rd -> addr_ins 0x20, 0x21, 0x22,
//     three cu_en pulses, 6 cycles ISSUE..EVAL, then pc+1.
//  3. Branch: IR=16'h3042, cw_last=cw_branch=1, zero_flag=1 -> next imem_addr=0x42;
//     with zero_flag=0 -> next imem_addr=pc+1.
//  4. stall held 5 cycles in ISSUE -> cu_en stays 0 throughout,
//     then a single pulse after stall falls.
//  5. cw_last never set, MAX_UOPS=8 -> exactly 8 cu_en pulses, then fault=1, halted=1;
//     start ignored afterwards.
//  6. pc=0xFF, non-branch last -> imem_addr=0x00.
//     rst asserted mid-FETCH with imem_valid late -> IDLE, imem_req=0, IR unchanged from 0.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Bus bundle between micro_sequencer, instruction memory and control_unit.
// The master side is the sequencer; the slave side is the memory/control-unit pair.
interface micro_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_data;
  logic [7:0]      addr_ins;
  logic [3:0]      operand1;
  logic [3:0]      operand2;
  logic            cu_en;
  logic            cw_last;
  logic            cw_branch;
  logic            zero_flag;
  logic            stall;

  modport master (
    output imem_req, imem_addr, addr_ins, operand1, operand2, cu_en,
    input  imem_valid, imem_data, cw_last, cw_branch, zero_flag, stall
  );

  modport slave (
    input  imem_req, imem_addr, addr_ins, operand1, operand2, cu_en,
    output imem_valid, imem_data, cw_last, cw_branch, zero_flag, stall
  );
endinterface

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute sequencer: fetches {opcode, op1, op2}, then steps control_unit
// through the opcode's micro-routine until the control word flags the last micro-op.
module micro_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter logic [7:0]  HALT_OP  = 8'hFF,
  parameter int unsigned MAX_UOPS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  micro_sequencer_if.master    bus,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault
);

  localparam int unsigned       UCNT_W    = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;
  localparam logic [UCNT_W-1:0] UCNT_LAST = UCNT_W'(MAX_UOPS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, EVAL, HALT
  } state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [7:0]        uaddr;
  logic [7:0]        addr_ins_r;
  logic [UCNT_W-1:0] ucnt;
  logic              imem_req_r;
  logic              cu_en_r;
  logic              issue_go;

  assign issue_go     = (state == ISSUE) && !bus.stall;

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = pc;
  assign bus.addr_ins  = addr_ins_r;
  assign bus.cu_en     = cu_en_r;
  assign bus.operand1  = ir[7:4];
  assign bus.operand2  = ir[3:0];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   if (bus.imem_valid) state_n = DECODE;
      DECODE:  state_n = (ir[15:8] == HALT_OP) ? HALT : ISSUE;
      ISSUE:   if (!bus.stall) state_n = EVAL;
      EVAL: begin
        if (bus.cw_last)           state_n = FETCH;
        else if (ucnt == UCNT_LAST) state_n = HALT;
        else                       state_n = ISSUE;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with 'state'.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      uaddr      <= '0;
      ucnt       <= '0;
      addr_ins_r <= '0;
      imem_req_r <= 1'b0;
      cu_en_r    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      imem_req_r <= (state_n == FETCH);
      busy       <= (state_n != IDLE) && (state_n != HALT);
      halted     <= (state_n == HALT);
      cu_en_r    <= issue_go;
      unique case (state)
        IDLE:   if (start) pc <= '0;
        FETCH:  if (bus.imem_valid) ir <= bus.imem_data;
        DECODE: begin
          uaddr <= ir[15:8];
          ucnt  <= '0;
        end
        ISSUE:  if (!bus.stall) addr_ins_r <= uaddr;
        EVAL: begin
          if (bus.cw_last) begin
            if (bus.cw_branch && bus.zero_flag) pc <= PC_W'(ir[7:0]);
            else                                pc <= pc + PC_W'(1);
          end else if (ucnt == UCNT_LAST) begin
            fault <= 1'b1;
          end else begin
            uaddr <= uaddr + 8'd1;
            ucnt  <= ucnt + UCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
